// File: rtl/skew_pkg.sv
// Shared types and helpers for the skew_line delay array.
// Holds the lane-mode enum and the per-lane depth function used by both the
// RTL generate loop and anything else that needs to know a lane's latency.
package skew_pkg;

  typedef enum logic {SKEW = 1'b0, DESKEW = 1'b1} skew_mode_e;

  // Depth of lane k. SKEW delays higher lanes more; DESKEW mirrors that so
  // lanes that arrived late from a skewed array are re-aligned.
  function automatic int lane_delay(int k, int C, int STEP, int BASE, skew_mode_e m);
    if (m == SKEW) return BASE + k * STEP;
    else           return BASE + (C - 1 - k) * STEP;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One {valid, data} delay chain of depth D.
// Ports:
//   c        clock (posedge)
//   r        synchronous active-high reset, clears every stage
//   e        shift enable, 0 freezes the chain
//   i_valid  input beat valid
//   i        input word
//   o        word leaving the last stage (combinational when D = 0)
//   o_valid  valid leaving the last stage
module skew_lane #(
  parameter int D = 1,
  parameter int W = 8
) (
  input  logic         c,
  input  logic         r,
  input  logic         e,
  input  logic         i_valid,
  input  logic [W-1:0] i,
  output logic [W-1:0] o,
  output logic         o_valid
);

  if (D == 0) begin : g_pass
    // Zero-depth lane: clock, reset and enable have no state to act on.
    logic unused_ctrl;
    assign unused_ctrl = ^{c, r, e};
    assign o       = i_valid ? i : '0;
    assign o_valid = i_valid;
  end else begin : g_chain
    logic [D-1:0]        valid_q, valid_d;
    logic [D-1:0][W-1:0] data_q, data_d;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (e) begin
        valid_d[0] = i_valid;
        // Bubbles carry zero data so downstream PEs never see stale words.
        data_d[0]  = i_valid ? i : '0;
        for (int s = 1; s < D; s++) begin
          valid_d[s] = valid_q[s-1];
          data_d[s]  = data_q[s-1];
        end
      end
    end

    always_ff @(posedge c) begin
      if (r) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign o       = data_q[D-1];
    assign o_valid = valid_q[D-1];
  end

endmodule

// File: rtl/skew_line.sv
// Multi-lane skew / de-skew delay line for the edges of a systolic array.
// Lane k is delayed by lane_delay(k); a 1-bit last tag rides alongside the
// slowest lane and an in-flight counter tracks beats not yet fully drained.
// Ports:
//   c, r, e   clock, sync active-high reset, shift enable
//   i_valid   input beat valid (all lanes)
//   i_last    input beat closes a frame
//   i         C words of W bits, lane k in i[k]
//   o/o_valid per-lane delayed data and valid
//   o_last    last tag at the slowest lane's delay
//   inflight  beats accepted whose slowest-lane copy has not emerged
//   busy      inflight != 0
module skew_line
  import skew_pkg::*;
#(
  parameter int C    = 4,
  parameter int W    = 8,
  parameter int STEP = 1,
  parameter int BASE = 0,
  parameter int MODE = 0,
  localparam int DMAX = BASE + (C - 1) * STEP,
  localparam int CW   = $clog2(DMAX + 2)
) (
  input  logic                c,
  input  logic                r,
  input  logic                e,
  input  logic                i_valid,
  input  logic                i_last,
  input  logic [C-1:0][W-1:0] i,
  output logic [C-1:0][W-1:0] o,
  output logic [C-1:0]        o_valid,
  output logic                o_last,
  output logic [CW-1:0]       inflight,
  output logic                busy
);

  localparam skew_mode_e MODE_E = (MODE == 0) ? SKEW : DESKEW;
  localparam int SLOW = (MODE_E == SKEW) ? C - 1 : 0;

  for (genvar k = 0; k < C; k++) begin : g_lane
    localparam int DK = lane_delay(k, C, STEP, BASE, MODE_E);
    skew_lane #(.D(DK), .W(W)) u_lane (
      .c       (c),
      .r       (r),
      .e       (e),
      .i_valid (i_valid),
      .i       (i[k]),
      .o       (o[k]),
      .o_valid (o_valid[k])
    );
  end

  if (DMAX == 0) begin : g_last_pass
    assign o_last = i_valid & i_last;
  end else begin : g_last_chain
    logic [DMAX-1:0] last_q, last_d;

    always_comb begin
      last_d = last_q;
      if (e) begin
        last_d[0] = i_valid & i_last;
        for (int s = 1; s < DMAX; s++) last_d[s] = last_q[s-1];
      end
    end

    always_ff @(posedge c) begin
      if (r) last_q <= '0;
      else   last_q <= last_d;
    end

    assign o_last = last_q[DMAX-1];
  end

  // A beat entering while another leaves the slowest lane nets to zero,
  // which also keeps the count at 0 when DMAX = 0.
  logic          inc, dec;
  logic [CW-1:0] inflight_q, inflight_d;

  assign inc = e & i_valid;
  assign dec = e & o_valid[SLOW];

  always_comb begin
    inflight_d = inflight_q;
    if (inc && !dec)      inflight_d = inflight_q + CW'(1);
    else if (dec && !inc) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge c) begin
    if (r) inflight_q <= '0;
    else   inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_skew_line.sv
// Directed bench for skew_line: one SKEW and one DESKEW instance share all
// inputs (C=4, W=8, STEP=1, BASE=0). Inputs change on the falling edge and
// outputs are compared 1 ns later, so each row's expectation is what the
// outputs show before the next rising edge.
module tb_skew_line;
  import skew_pkg::*;

  logic        c = 1'b0;
  logic        r, e, v, l;
  logic [31:0] d;
  logic [31:0] o_s, o_d;
  logic [3:0]  ov_s, ov_d;
  logic        last_s, last_d;
  logic [2:0]  inf_s, inf_d;
  logic        busy_s, busy_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 c = ~c;

  skew_line #(.C(4), .W(8), .STEP(1), .BASE(0), .MODE(0)) dut_s (
    .c(c), .r(r), .e(e), .i_valid(v), .i_last(l), .i(d),
    .o(o_s), .o_valid(ov_s), .o_last(last_s), .inflight(inf_s), .busy(busy_s)
  );

  skew_line #(.C(4), .W(8), .STEP(1), .BASE(0), .MODE(1)) dut_d (
    .c(c), .r(r), .e(e), .i_valid(v), .i_last(l), .i(d),
    .o(o_d), .o_valid(ov_d), .o_last(last_d), .inflight(inf_d), .busy(busy_d)
  );

  typedef struct {
    logic        r, e, v, l;
    logic [31:0] d;
    logic        ck;
    logic [31:0] eo;
    logic [3:0]  eov;
    logic        el;
    logic [2:0]  ei;
    logic [31:0] eod;
    logic [3:0]  eovd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r_, input logic e_, input logic v_, input logic l_,
                       input logic [31:0] d_);
    @(negedge c);
    r = r_; e = e_; v = v_; l = l_; d = d_;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] eo, input logic [3:0] eov,
                           input logic el, input logic [2:0] ei,
                           input logic [31:0] eod, input logic [3:0] eovd);
    chk({tag, " skew o"},        o_s,              eo);
    chk({tag, " skew o_valid"},  32'(ov_s),        32'(eov));
    chk({tag, " skew o_last"},   32'(last_s),      32'(el));
    chk({tag, " skew inflight"}, 32'(inf_s),       32'(ei));
    chk({tag, " skew busy"},     32'(busy_s),      32'(ei != 3'd0));
    chk({tag, " desk o"},        o_d,              eod);
    chk({tag, " desk o_valid"},  32'(ov_d),        32'(eovd));
    chk({tag, " desk o_last"},   32'(last_d),      32'(el));
    chk({tag, " desk inflight"}, 32'(inf_d),       32'(ei));
  endtask

  initial begin
    r = 1'b1; e = 1'b1; v = 1'b0; l = 1'b0; d = '0;

    //            r    e    v    l    d             ck   skew o        ov       last ei    desk o        ovd
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,32'h00000000,1'b0,32'h00000000,4'b0000,1'b0,3'd0,32'h00000000,4'b0000};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00000000,4'b0000,1'b0,3'd0,32'h00000000,4'b0000};
    // single beat
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,32'h44332211,1'b1,32'h00000011,4'b0001,1'b0,3'd0,32'h44000000,4'b1000};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00002200,4'b0010,1'b0,3'd1,32'h00330000,4'b0100};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00330000,4'b0100,1'b0,3'd1,32'h00002200,4'b0010};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h44000000,4'b1000,1'b0,3'd1,32'h00000011,4'b0001};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00000000,4'b0000,1'b0,3'd0,32'h00000000,4'b0000};
    // bubbles: valid 1,0,1 with all-ones data, bubble must carry zeros
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,32'hFFFFFFFF,1'b1,32'h000000FF,4'b0001,1'b0,3'd0,32'hFF000000,4'b1000};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,32'hFFFFFFFF,1'b1,32'h0000FF00,4'b0010,1'b0,3'd1,32'h00FF0000,4'b0100};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,32'hFFFFFFFF,1'b1,32'h00FF00FF,4'b0101,1'b0,3'd1,32'hFF00FF00,4'b1010};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,32'hFFFFFFFF,1'b1,32'hFF00FF00,4'b1010,1'b0,3'd2,32'h00FF00FF,4'b0101};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,32'hFFFFFFFF,1'b1,32'h00FF0000,4'b0100,1'b0,3'd1,32'h0000FF00,4'b0010};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'hFF000000,4'b1000,1'b0,3'd1,32'h000000FF,4'b0001};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00000000,4'b0000,1'b0,3'd0,32'h00000000,4'b0000};
    // 3-beat frame, last on beat 3; a stray i_last on an idle cycle must not tag
    tbl[14] = '{1'b0,1'b1,1'b1,1'b0,32'h04030201,1'b1,32'h00000001,4'b0001,1'b0,3'd0,32'h04000000,4'b1000};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b0,32'h08070605,1'b1,32'h00000205,4'b0011,1'b0,3'd1,32'h08030000,4'b1100};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b1,32'h0C0B0A09,1'b1,32'h00030609,4'b0111,1'b0,3'd2,32'h0C070200,4'b1110};
    tbl[17] = '{1'b0,1'b1,1'b0,1'b1,32'h00000000,1'b1,32'h04070A00,4'b1110,1'b0,3'd3,32'h000B0601,4'b0111};
    tbl[18] = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h080B0000,4'b1100,1'b0,3'd2,32'h00000A05,4'b0011};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h0C000000,4'b1000,1'b1,3'd1,32'h00000009,4'b0001};
    tbl[20] = '{1'b0,1'b1,1'b0,1'b0,32'h00000000,1'b1,32'h00000000,4'b0000,1'b0,3'd0,32'h00000000,4'b0000};

    for (int n = 0; n < 21; n++) begin
      drive(tbl[n].r, tbl[n].e, tbl[n].v, tbl[n].l, tbl[n].d);
      if (tbl[n].ck)
        check_out($sformatf("row%0d", n), tbl[n].eo, tbl[n].eov, tbl[n].el, tbl[n].ei,
                  tbl[n].eod, tbl[n].eovd);
    end

    // Stall: beats 1,2 accepted, then e=0 for 5 cycles while beat 3 is held
    // on the inputs, then beats 3,4 and a drain.
    drive(0, 1, 1, 0, 32'h13121110);
    check_out("stall s0", 32'h00000010, 4'b0001, 0, 3'd0, 32'h13000000, 4'b1000);
    drive(0, 1, 1, 0, 32'h23222120);
    check_out("stall s1", 32'h00001120, 4'b0011, 0, 3'd1, 32'h23120000, 4'b1100);
    for (int s = 0; s < 5; s++) begin
      drive(0, 0, 1, 0, 32'h33323130);
      check_out($sformatf("stall hold%0d", s), 32'h00122130, 4'b0111, 0, 3'd2,
                32'h33221100, 4'b1110);
    end
    drive(0, 1, 1, 0, 32'h33323130);
    check_out("stall s7", 32'h00122130, 4'b0111, 0, 3'd2, 32'h33221100, 4'b1110);
    drive(0, 1, 1, 0, 32'h43424140);
    check_out("stall s8", 32'h13223140, 4'b1111, 0, 3'd3, 32'h43322110, 4'b1111);
    drive(0, 1, 0, 0, 32'h00000000);
    check_out("stall s9", 32'h23324100, 4'b1110, 0, 3'd3, 32'h00423120, 4'b0111);
    drive(0, 1, 0, 0, 32'h00000000);
    check_out("stall s10", 32'h33420000, 4'b1100, 0, 3'd2, 32'h00004130, 4'b0011);
    drive(0, 1, 0, 0, 32'h00000000);
    check_out("stall s11", 32'h43000000, 4'b1000, 0, 3'd1, 32'h00000040, 4'b0001);
    drive(0, 1, 0, 0, 32'h00000000);
    check_out("stall s12", 32'h00000000, 4'b0000, 0, 3'd0, 32'h00000000, 4'b0000);

    // Reset with three beats in flight (last tag on the third), enable high.
    drive(0, 1, 1, 0, 32'h5A5A5A5A);
    drive(0, 1, 1, 0, 32'h6B6B6B6B);
    drive(0, 1, 1, 1, 32'h7C7C7C7C);
    drive(1, 1, 1, 0, 32'h11111111);
    chk("rst pre skew inflight", 32'(inf_s), 32'd3);
    chk("rst pre desk inflight", 32'(inf_d), 32'd3);
    for (int s = 0; s < 4; s++) begin
      drive(0, 1, 0, 0, 32'h00000000);
      check_out($sformatf("rst_e1 post%0d", s), 32'h0, 4'b0000, 0, 3'd0, 32'h0, 4'b0000);
    end

    // Reset while the enable is low must still clear.
    drive(0, 1, 1, 0, 32'h21212121);
    drive(0, 1, 1, 0, 32'h32323232);
    drive(1, 0, 0, 0, 32'h00000000);
    chk("rst_e0 pre skew inflight", 32'(inf_s), 32'd2);
    chk("rst_e0 pre desk inflight", 32'(inf_d), 32'd2);
    drive(0, 0, 0, 0, 32'h00000000);
    check_out("rst_e0 held", 32'h0, 4'b0000, 0, 3'd0, 32'h0, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      drive(0, 1, 0, 0, 32'h00000000);
      check_out($sformatf("rst_e0 post%0d", s), 32'h0, 4'b0000, 0, 3'd0, 32'h0, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
